// File: rtl/pic_fetch_seq.sv
// Fetch/sequencing stage for a 12-bit-opcode PIC core: PC, 2-level call stack, IR.
// Optional stack depth checking with sticky stk_err is enabled by defining FETCH_STACK_CHK_EN.
module pic_fetch_seq #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(8'hFF)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [11:0]     imem_data,
  input  logic            stall,
  input  logic            skip,
  output logic [11:0]     opcode,
  output logic            op_valid
`ifdef FETCH_STACK_CHK_EN
  ,
  output logic            stk_err
`endif
);

  typedef enum logic [2:0] {
    ACT_FETCH,
    ACT_GOTO,
    ACT_CALL,
    ACT_RET,
    ACT_SKIP
  } act_e;

  logic [PC_W-1:0] pc, s0, s1;
  logic [11:0]     ir;
  logic            vld;
  act_e            act;
  logic [PC_W-1:0] pc_inc, goto_tgt, call_tgt;

`ifdef FETCH_STACK_CHK_EN
  logic [1:0] depth;
`endif

  assign pc_inc   = pc + PC_W'(1);
  assign goto_tgt = PC_W'(ir[8:0]);
  assign call_tgt = PC_W'(ir[7:0]);

  // Branches outrank skip; a bubble (vld=0) can neither branch nor skip.
  always_comb begin
    act = ACT_FETCH;
    if (vld) begin
      if (ir[11:9] == 3'b101)      act = ACT_GOTO;
      else if (ir[11:8] == 4'b1001) act = ACT_CALL;
      else if (ir[11:8] == 4'b1000) act = ACT_RET;
      else if (skip)                act = ACT_SKIP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_VEC;
      ir  <= 12'h000;
      vld <= 1'b0;
      s0  <= '0;
      s1  <= '0;
`ifdef FETCH_STACK_CHK_EN
      depth   <= 2'd0;
      stk_err <= 1'b0;
`endif
    end else if (!stall) begin
      unique case (act)
        ACT_GOTO: begin
          pc  <= goto_tgt;
          ir  <= 12'h000;
          vld <= 1'b0;
        end
        ACT_CALL: begin
          s1  <= s0;
          s0  <= pc;
          pc  <= call_tgt;
          ir  <= 12'h000;
          vld <= 1'b0;
`ifdef FETCH_STACK_CHK_EN
          if (depth == 2'd2) stk_err <= 1'b1;
          else               depth   <= depth + 2'd1;
`endif
        end
        ACT_RET: begin
          pc  <= s0;
          s0  <= s1;
          ir  <= 12'h000;
          vld <= 1'b0;
`ifdef FETCH_STACK_CHK_EN
          if (depth == 2'd0) stk_err <= 1'b1;
          else               depth   <= depth - 2'd1;
`endif
        end
        ACT_SKIP: begin
          pc  <= pc_inc;
          ir  <= 12'h000;
          vld <= 1'b0;
        end
        ACT_FETCH: begin
          pc  <= pc_inc;
          ir  <= imem_data;
          vld <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir;
  assign op_valid  = vld;

endmodule

// File: tb/tb_pic_fetch_seq.sv
// Directed bench for pic_fetch_seq: a small program in a behavioural ROM, per-cycle
// expected fetch state queued in a scoreboard and compared after each rising edge.
module tb_pic_fetch_seq;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] imem_addr;
  logic [11:0]     imem_data;
  logic            stall;
  logic            skip;
  logic [11:0]     opcode;
  logic            op_valid;
`ifdef FETCH_STACK_CHK_EN
  logic            stk_err;
`endif

  logic [11:0] mem [0:255];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  pic_fetch_seq #(.PC_W(PC_W), .RESET_VEC(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .stall     (stall),
    .skip      (skip),
    .opcode    (opcode),
    .op_valid  (op_valid)
`ifdef FETCH_STACK_CHK_EN
    ,
    .stk_err   (stk_err)
`endif
  );

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] op;
    logic        vld;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Queue the expected post-edge state, advance one edge, then compare.
  task automatic step(input string tag, input logic [7:0] a, input logic [11:0] op,
                      input logic v, input logic err);
    exp_t e;
    sb.push_back('{addr: a, op: op, vld: v, err: err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".addr"}, 32'(imem_addr), 32'(e.addr));
    chk({tag, ".op"},   32'(opcode),    32'(e.op));
    chk({tag, ".vld"},  32'(op_valid),  32'(e.vld));
`ifdef FETCH_STACK_CHK_EN
    chk({tag, ".err"},  32'(stk_err),   32'(e.err));
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".addr"}, 32'(imem_addr), 32'h0FF);
    chk({tag, ".op"},   32'(opcode),    32'h000);
    chk({tag, ".vld"},  32'(op_valid),  32'h0);
`ifdef FETCH_STACK_CHK_EN
    chk({tag, ".err"},  32'(stk_err),   32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 12'hFFF;
    mem[8'hFF] = 12'hC25;  // MOVLW calibration
    mem[8'h00] = 12'h000;
    mem[8'h01] = 12'h0A1;
    mem[8'h02] = 12'h0A2;
    mem[8'h03] = 12'h910;  // CALL 0x10
    mem[8'h04] = 12'h0A4;
    mem[8'h05] = 12'hA40;  // GOTO 0x40
    mem[8'h06] = 12'h0A6;
    mem[8'h07] = 12'h2E7;  // DECFSZ, skip taken
    mem[8'h08] = 12'h0A8;
    mem[8'h09] = 12'h0A9;
    mem[8'h0A] = 12'hA20;  // GOTO 0x20, stalled in ir
    mem[8'h0B] = 12'h0AB;
    mem[8'h10] = 12'h8AB;  // RETLW
    mem[8'h11] = 12'h0B1;
    mem[8'h20] = 12'h0C0;
    mem[8'h21] = 12'hA60;  // GOTO 0x60
    mem[8'h40] = 12'h0D0;
    mem[8'h41] = 12'h0D1;
    mem[8'h42] = 12'hA07;  // GOTO 0x07
    mem[8'h43] = 12'h0D3;
    mem[8'h60] = 12'h970;  // CALL 0x70
    mem[8'h70] = 12'h980;  // CALL 0x80
    mem[8'h80] = 12'h990;  // CALL 0x90
    mem[8'h90] = 12'h8A1;  // RETLW
    mem[8'h81] = 12'h8A2;  // RETLW
    mem[8'h71] = 12'h8A3;  // RETLW

    rst = 1'b1; stall = 1'b0; skip = 1'b0;
    #12;
    chk_reset("reset");
    rst = 1'b0;

    // Reset vector fetch and wrap FF -> 00 -> 01
    step("e01", 8'h00, 12'hC25, 1'b1, 1'b0);
    step("e02", 8'h01, 12'h000, 1'b1, 1'b0);
    step("e03", 8'h02, 12'h0A1, 1'b1, 1'b0);
    step("e04", 8'h03, 12'h0A2, 1'b1, 1'b0);
    step("e05", 8'h04, 12'h910, 1'b1, 1'b0);
    // CALL then RETLW back to 04
    step("call", 8'h10, 12'h000, 1'b0, 1'b0);
    step("e07",  8'h11, 12'h8AB, 1'b1, 1'b0);
    step("ret",  8'h04, 12'h000, 1'b0, 1'b0);
    step("e09",  8'h05, 12'h0A4, 1'b1, 1'b0);
    step("e10",  8'h06, 12'hA40, 1'b1, 1'b0);
    // GOTO 0x40
    step("goto", 8'h40, 12'h000, 1'b0, 1'b0);
    step("e12",  8'h41, 12'h0D0, 1'b1, 1'b0);
    step("e13",  8'h42, 12'h0D1, 1'b1, 1'b0);
    step("e14",  8'h43, 12'hA07, 1'b1, 1'b0);
    step("goto7", 8'h07, 12'h000, 1'b0, 1'b0);
    step("e16",  8'h08, 12'h2E7, 1'b1, 1'b0);
    // Skip the word at 08
    skip = 1'b1;
    step("skip", 8'h09, 12'h000, 1'b0, 1'b0);
    skip = 1'b0;
    step("e18",  8'h0A, 12'h0A9, 1'b1, 1'b0);
    step("e19",  8'h0B, 12'hA20, 1'b1, 1'b0);
    // Stall three cycles with GOTO in ir
    stall = 1'b1;
    step("stall1", 8'h0B, 12'hA20, 1'b1, 1'b0);
    step("stall2", 8'h0B, 12'hA20, 1'b1, 1'b0);
    step("stall3", 8'h0B, 12'hA20, 1'b1, 1'b0);
    stall = 1'b0;
    step("goto20", 8'h20, 12'h000, 1'b0, 1'b0);
    // Skip during a bubble is ignored
    skip = 1'b1;
    step("skipbub", 8'h21, 12'h0C0, 1'b1, 1'b0);
    skip = 1'b0;
    step("e25",  8'h22, 12'hA60, 1'b1, 1'b0);
    step("goto60", 8'h60, 12'h000, 1'b0, 1'b0);
    // Three nested CALLs, then three RETLWs
    step("e27",  8'h61, 12'h970, 1'b1, 1'b0);
    step("call1", 8'h70, 12'h000, 1'b0, 1'b0);
    step("e29",  8'h71, 12'h980, 1'b1, 1'b0);
    step("call2", 8'h80, 12'h000, 1'b0, 1'b0);
    step("e31",  8'h81, 12'h990, 1'b1, 1'b0);
    step("call3", 8'h90, 12'h000, 1'b0, 1'b1);
    step("e33",  8'h91, 12'h8A1, 1'b1, 1'b1);
    step("ret1", 8'h81, 12'h000, 1'b0, 1'b1);
    step("e35",  8'h82, 12'h8A2, 1'b1, 1'b1);
    step("ret2", 8'h71, 12'h000, 1'b0, 1'b1);
    step("e37",  8'h72, 12'h8A3, 1'b1, 1'b1);
    step("ret3", 8'h71, 12'h000, 1'b0, 1'b1);
    step("e39",  8'h72, 12'h8A3, 1'b1, 1'b1);

    // Asynchronous reset mid-stall, away from any clock edge
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_async");
    #2;
    rst = 1'b0;
    stall = 1'b0;
    step("r01", 8'h00, 12'hC25, 1'b1, 1'b0);
    step("r02", 8'h01, 12'h000, 1'b1, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pic_fetch_seq.md
# pic_fetch_seq

Instruction fetch and sequencing stage for the 12-bit-opcode PIC10F200-class core. It sits directly upstream of the combinational ALU/decode stage. It owns the program counter, the 2-level hardware call stack and the instruction register. It drives the 12-bit `opcode` consumed by the ALU each cycle. Branches and skips are resolved here by squashing the already-fetched word, which inserts a NOP bubble.

## Interface
- `PC_W`, 8, program counter / memory address width (8 or 9).
- `RESET_VEC`, 8'hFF, PC value loaded on reset (holds the calibration MOVLW).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  PC_W  program memory address; equals PC.
- `imem_data`  in  12  program word at `imem_addr`, combinational (same-cycle) read.
- `stall`  in  1  hold all state this cycle.
- `skip`  in  1  from execute: squash the word following the current `opcode` (xxxFSZ/BTFSx taken).
- `opcode`  out  12  instruction register, to ALU.
- `op_valid`  out  1  1 = `opcode` is a real instruction; 0 = bubble (forced 12'h000 NOP).
- `stk_err`  out  1  sticky stack over/underflow flag. Present only with the macro defined (see Configuration).

## Operation
- Registers:
  - `pc` [PC_W]
  - `ir` [12]
  - `vld`
  - stack `s0`, `s1` [PC_W]
  - `depth` [2] (0..2, present with the macro only).
- Decode of `ir` (only when `vld`=1):
  - GOTO: `ir[11:9]`=3'b101, target = `ir[8:0]` truncated to PC_W.
  - CALL: `ir[11:8]`=4'b1001, target = `ir[7:0]` zero-extended to PC_W (bit 8 cleared).
  - RETLW: `ir[11:8]`=4'b1000, target = `s0`.
- Per edge with `stall`=0, first match wins:
  - GOTO: `pc`<=target; `ir`<=0; `vld`<=0.
  - CALL: `s1`<=`s0`; `s0`<=`pc`; `pc`<=target; `ir`<=0; `vld`<=0.
  - RETLW: `pc`<=`s0`; `s0`<=`s1` (`s1` unchanged); `ir`<=0; `vld`<=0.
  - `skip`=1: `pc`<=`pc`+1; `ir`<=0; `vld`<=0. The fetched word is discarded.
  - Otherwise: `ir`<=`imem_data`; `vld`<=1; `pc`<=`pc`+1.
- `pc`+1 wraps modulo 2^PC_W (8'hFF -> 8'h00).
- `stall`=1: every register holds. `skip` and branch decode are ignored that cycle; execute must hold `skip` until the stall releases.
- `skip` is ignored while `vld`=0, since a bubble cannot request a skip.
- `skip` together with a branch in `ir`: the branch wins. The outcome is a bubble either way.
- Stack is not memory-mapped. There is no overflow trap in base behaviour: a third CALL silently loses the oldest entry, and a RETLW from an empty stack returns the stale `s0`.

## Timing
- Reset (async, immediate): `pc`=RESET_VEC, `ir`=12'h000, `op_valid`=0, `s0`=`s1`=0, `depth`=0, `stk_err`=0.
- First edge after reset release fetches `imem_data`@RESET_VEC; `opcode` is valid in the following cycle.
- Fetch-to-`opcode` latency: 1 cycle. Sustained throughput is 1 instruction/cycle.
- GOTO/CALL/RETLW/taken skip: exactly 1 bubble cycle (`op_valid`=0). The target word appears as `opcode` 2 cycles after the branch was in `ir`.
- `skip` is sampled at the same edge that would load the next word. It must be valid in the cycle its instruction is on `opcode`.
- `rst` mid-branch or mid-stall discards everything. There is no partial stack update.

## Configuration
- `FETCH_STACK_CHK_EN` defined:
  - Adds the `depth` counter and the `stk_err` port.
  - CALL at `depth`=2 sets `stk_err` (the push still happens and `depth` stays 2).
  - RETLW at `depth`=0 sets `stk_err` (the pop still happens and `depth` stays 0).
  - Otherwise CALL increments `depth` and RETLW decrements it.
  - `stk_err` clears only on `rst`.
- Not defined: no `depth` and no `stk_err` port. Stack behaviour is otherwise identical.

## Test plan
- Reset then run with mem[FF]=12'hC25, mem[00]=12'h000: `imem_addr` FF -> 00 -> 01. `opcode`=12'hC25 with `op_valid`=1 in cycle 2, then 12'h000 with `op_valid`=1.
- GOTO 12'hA40 at address 05: one cycle with `op_valid`=0, next `imem_addr`=8'h40, mem[40] on `opcode` 2 cycles after the GOTO.
- CALL 12'h910 at 03, RETLW 12'h8AB at 10: `s0`=04 after CALL; RETLW returns `imem_addr`=04; one bubble after each branch.
- `skip`=1 while DECFSZ at 07 is on `opcode`: word at 08 never reaches `opcode` with `op_valid`=1, and the word at 09 follows the bubble.
- `stall`=1 for 3 cycles mid-stream, including while GOTO is in `ir`: `imem_addr`, `opcode` and `op_valid` are frozen; the GOTO resolves on the first unstalled edge.
- With `FETCH_STACK_CHK_EN`, three nested CALLs: `stk_err` rises on the third CALL's edge and stays 1 through later RETLWs until `rst`. Without the macro, the port is absent and the third RETLW returns to the second call site.
